matrix_scan_ctrl: RTL and testbench

- Scan sequencer that drives the badge CPLD's LED-matrix interface: the row shift clock/data and the 4-bit column select.
- Holds a double-buffered 16x16 framebuffer and shifts one column of row data out per column period.
- Advances the column select, dwells, and repeats, wrapping after column 15.
- Also synchronises and debounces the CPLD's 3-bit encoded button code.

---
 rtl/matrix_scan_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_matrix_scan_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: LED-matrix scan sequencer for the badge CPLD.
// Shifts one 16-bit column of row data out of the front framebuffer per
// column period, latches the column select, dwells, and advances 0..15.
// Also synchronises and debounces the CPLD's 3-bit encoded button code.
// Optional build macro MATRIX_SCAN_ROW_INVERT_EN: drives out_row_data with
// inverted polarity (idle level 1) for active-low row drivers.
module matrix_scan_ctrl #(
    parameter int CLK_DIV         = 2,
    parameter int DWELL_CYCLES    = 64,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic        in_clk,
    input  logic        in_reset,
    input  logic        in_enable,
    input  logic        in_fb_we,
    input  logic [3:0]  in_fb_addr,
    input  logic [15:0] in_fb_data,
    input  logic        in_swap,
    input  logic [2:0]  in_button_code,
    output logic        out_row_clk,
    output logic        out_row_data,
    output logic [3:0]  out_column,
    output logic        out_frame,
    output logic        out_swap_done,
    output logic [2:0]  out_button,
    output logic        out_button_event
);

    localparam int DIV_W   = $clog2(2 * CLK_DIV);
    localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_HIGH   = DIV_W'(CLK_DIV);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        DWELL = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // div_cnt walks one row bit: low half then high half of out_row_clk
    logic [DIV_W-1:0]   div_cnt;
    logic [3:0]         bit_cnt;
    logic [DWELL_W-1:0] dwell_cnt;
    // col is the column being scanned, or the next one to scan while idle
    logic [3:0]         col;

    logic [15:0]        fb [2][16];
    logic               front;
    logic               swap_pending;
    logic               swap_apply;
    logic [15:0]        front_word;

    logic               shift_last;
    logic               dwell_last;
    logic               frame_end;
    logic               row_bit;

    logic [2:0]         sync1;
    logic [2:0]         sync2;
    logic [DEB_W-1:0]   deb_cnt;

    assign front_word = fb[front][col];
    assign shift_last = (state == SHIFT) && (bit_cnt == 4'd15) && (div_cnt == DIV_LAST);
    assign dwell_last = (state == DWELL) && (dwell_cnt == DWELL_LAST);
    assign frame_end  = dwell_last && (col == 4'd15);
    // A pending swap lands at the frame boundary, or straight away when idle
    assign swap_apply = swap_pending && (frame_end || (state == IDLE));

    // State register
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; in_enable only matters in IDLE and at a column boundary
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_enable) state_next = SHIFT;
            SHIFT:   if (shift_last) state_next = LATCH;
            LATCH:   state_next = DWELL;
            DWELL:   if (dwell_last) state_next = in_enable ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: row clock/data only toggle during SHIFT, MSB first
    always_comb begin
        out_row_clk   = 1'b0;
        row_bit       = 1'b0;
        out_frame     = frame_end;
        out_swap_done = swap_apply;
        if (state == SHIFT) begin
            out_row_clk = (div_cnt >= DIV_HIGH);
            row_bit     = front_word[~bit_cnt];
        end
    end

`ifdef MATRIX_SCAN_ROW_INVERT_EN
    assign out_row_data = ~row_bit;
`else
    assign out_row_data = row_bit;
`endif

    // Scan counters, column select latch and column advance
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            dwell_cnt  <= '0;
            col        <= '0;
            out_column <= '0;
        end else begin
            case (state)
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        bit_cnt <= bit_cnt + 4'd1;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                LATCH: begin
                    out_column <= col;
                    dwell_cnt  <= '0;
                end
                DWELL: begin
                    if (dwell_last) begin
                        dwell_cnt <= '0;
                        col       <= col + 4'd1;
                    end else begin
                        dwell_cnt <= dwell_cnt + DWELL_W'(1);
                    end
                end
                default: begin
                    div_cnt   <= '0;
                    bit_cnt   <= '0;
                    dwell_cnt <= '0;
                end
            endcase
        end
    end

    // Double-buffered framebuffer: writes go to the back buffer only;
    // a write coinciding with a swap lands in the pre-swap back buffer
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < 16; c++) begin
                    fb[b][c] <= '0;
                end
            end
            front        <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            if (in_fb_we) begin
                fb[~front][in_fb_addr] <= in_fb_data;
            end
            if (swap_apply) begin
                front        <= ~front;
                swap_pending <= 1'b0;
            end else if (in_swap) begin
                swap_pending <= 1'b1;
            end
        end
    end

    // Button synchroniser and debouncer; only non-zero codes raise an event
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            sync1            <= '0;
            sync2            <= '0;
            deb_cnt          <= '0;
            out_button       <= '0;
            out_button_event <= 1'b0;
        end else begin
            sync1            <= in_button_code;
            sync2            <= sync1;
            out_button_event <= 1'b0;
            if (sync1 != sync2) begin
                deb_cnt <= '0;
            end else if (deb_cnt != DEB_LAST) begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
            if ((deb_cnt == DEB_LAST) && (sync2 != out_button)) begin
                out_button       <= sync2;
                out_button_event <= (sync2 != 3'd0);
            end
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Testbench for matrix_scan_ctrl: per-cycle checks of the scan outputs and
// the debounced button outputs against a behavioural model of the display
// buffers and of the debounce window.
module tb_matrix_scan_ctrl;

    localparam int CLK_DIV      = 2;
    localparam int DWELL        = 64;
    localparam int DEB          = 1024;
    localparam int SHIFT_LEN    = 32 * CLK_DIV;
    localparam int COL_PERIOD   = SHIFT_LEN + 1 + DWELL;
    localparam int FRAME_PERIOD = 16 * COL_PERIOD;

`ifdef MATRIX_SCAN_ROW_INVERT_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        in_reset = 1'b1;
    logic        in_enable = 1'b0;
    logic        in_fb_we = 1'b0;
    logic [3:0]  in_fb_addr = '0;
    logic [15:0] in_fb_data = '0;
    logic        in_swap = 1'b0;
    logic [2:0]  in_button_code = '0;
    logic        out_row_clk;
    logic        out_row_data;
    logic [3:0]  out_column;
    logic        out_frame;
    logic        out_swap_done;
    logic [2:0]  out_button;
    logic        out_button_event;

    matrix_scan_ctrl #(
        .CLK_DIV(CLK_DIV),
        .DWELL_CYCLES(DWELL),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .in_clk(clk),
        .in_reset(in_reset),
        .in_enable(in_enable),
        .in_fb_we(in_fb_we),
        .in_fb_addr(in_fb_addr),
        .in_fb_data(in_fb_data),
        .in_swap(in_swap),
        .in_button_code(in_button_code),
        .out_row_clk(out_row_clk),
        .out_row_data(out_row_data),
        .out_column(out_column),
        .out_frame(out_frame),
        .out_swap_done(out_swap_done),
        .out_button(out_button),
        .out_button_event(out_button_event)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    // Display model: what the panel should show, as two plain arrays
    logic [15:0] m_front [16];
    logic [15:0] m_back  [16];
    bit          m_pend;
    int          lit_col;
    bit          period_chk;
    int          last_frame;

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_front[i] = '0;
            m_back[i]  = '0;
        end
        m_pend  = 1'b0;
        lit_col = 0;
    endtask

    task automatic model_swap();
        logic [15:0] tmp;
        for (int i = 0; i < 16; i++) begin
            tmp        = m_front[i];
            m_front[i] = m_back[i];
            m_back[i]  = tmp;
        end
        m_pend = 1'b0;
    endtask

    // Called on the first SHIFT cycle of column col; returns one column later.
    // Optional write/swap/enable stimulus is applied at cycle 10 of the column.
    task automatic scan_column(input int col, input bit do_wr, input int wr_addr,
                               input logic [15:0] wr_data, input bit do_swap,
                               input bit en_val, output bit cont);
        logic [15:0] word;
        logic [15:0] cap;
        int          edges;
        logic        prev_rc;
        logic        e_rc, e_rd, e_fr, e_sd;
        int          e_col;
        logic [7:0]  got, exp;
        word    = m_front[col];
        cap     = '0;
        edges   = 0;
        prev_rc = 1'b0;
        cont    = 1'b1;
        for (int t = 0; t < COL_PERIOD; t++) begin
            e_rc  = 1'b0;
            e_rd  = 1'b0;
            e_col = (t > SHIFT_LEN) ? col : lit_col;
            if (t < SHIFT_LEN) begin
                e_rc = ((t % (2 * CLK_DIV)) >= CLK_DIV);
                e_rd = word[15 - t / (2 * CLK_DIV)];
            end
            e_fr = (t == COL_PERIOD - 1) && (col == 15);
            e_sd = e_fr && m_pend;
            got = {out_row_clk, out_row_data, out_column, out_frame, out_swap_done};
            exp = {e_rc, e_rd ^ INV, 4'(e_col), e_fr, e_sd};
            n_total++;
            if (got !== exp)
                $display("FAIL scan col=%0d t=%0d got(rc,rd,col,frm,swp)=%b want=%b", col, t, got, exp);
            else
                n_pass++;
            if (out_row_clk === 1'b1 && prev_rc === 1'b0) begin
                cap = {cap[14:0], out_row_data};
                edges++;
            end
            prev_rc = out_row_clk;
            if (out_frame === 1'b1) begin
                if (period_chk && last_frame >= 0) begin
                    n_total++;
                    if (cyc - last_frame != FRAME_PERIOD)
                        $display("FAIL frame_period got=%0d want=%0d", cyc - last_frame, FRAME_PERIOD);
                    else
                        n_pass++;
                end
                last_frame = cyc;
            end
            if (t == 10) begin
                if (do_wr) begin
                    in_fb_we   = 1'b1;
                    in_fb_addr = 4'(wr_addr);
                    in_fb_data = wr_data;
                    m_back[wr_addr] = wr_data;
                end
                if (do_swap) begin
                    in_swap = 1'b1;
                    m_pend  = 1'b1;
                end
                in_enable = en_val;
            end
            if (t == 11) begin
                in_fb_we = 1'b0;
                in_swap  = 1'b0;
            end
            if (t == COL_PERIOD - 1) begin
                cont = in_enable;
                if (e_fr && m_pend) model_swap();
            end
            @(negedge clk);
        end
        n_total++;
        if (cap !== (word ^ {16{INV}}) || edges != 16)
            $display("FAIL row_word col=%0d got=%h/%0d edges want=%h/16 edges", col, cap, edges, word ^ {16{INV}});
        else
            n_pass++;
        lit_col = col;
    endtask

    task automatic scan_range(input int first, input int last);
        bit c;
        for (int k = first; k <= last; k++) scan_column(k, 1'b0, 0, 16'h0, 1'b0, 1'b1, c);
    endtask

    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            n_total++;
            if ({out_row_clk, out_row_data, out_column, out_frame, out_swap_done} !==
                {1'b0, INV, 4'(lit_col), 1'b0, 1'b0})
                $display("FAIL idle i=%0d got rc=%b rd=%b col=%0d frm=%b swp=%b want col=%0d",
                         i, out_row_clk, out_row_data, out_column, out_frame, out_swap_done, lit_col);
            else
                n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        in_reset = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({out_row_clk, out_row_data, out_column, out_frame, out_swap_done, out_button, out_button_event} !==
            {1'b0, INV, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0})
            $display("FAIL reset_outputs got rc=%b rd=%b col=%0d frm=%b swp=%b btn=%0d ev=%b",
                     out_row_clk, out_row_data, out_column, out_frame, out_swap_done, out_button, out_button_event);
        else
            n_pass++;
        in_reset = 1'b0;
        model_clear();
        @(negedge clk);
        check_idle(3);
    endtask

    task automatic test_first_column();
        in_fb_we   = 1'b1;
        in_fb_addr = 4'd0;
        in_fb_data = 16'h8001;
        m_back[0]  = 16'h8001;
        @(negedge clk);
        in_fb_we = 1'b0;
        in_swap  = 1'b1;
        m_pend   = 1'b1;
        @(negedge clk);
        in_swap = 1'b0;
        n_total++;
        if (out_swap_done !== 1'b1)
            $display("FAIL swap_idle got=%b want=1", out_swap_done);
        else
            n_pass++;
        model_swap();
        @(negedge clk);
        n_total++;
        if (out_swap_done !== 1'b0)
            $display("FAIL swap_idle_once got=%b want=0", out_swap_done);
        else
            n_pass++;
        in_enable = 1'b1;
        @(negedge clk);
        scan_range(0, 1);
    endtask

    task automatic test_free_run();
        period_chk = 1'b1;
        last_frame = -1;
        scan_range(2, 15);
        scan_range(0, 15);
    endtask

    task automatic test_swap_midframe();
        bit c;
        scan_range(0, 0);
        scan_column(1, 1'b1, 3, 16'hFFFF, 1'b0, 1'b1, c);
        scan_range(2, 4);
        scan_column(5, 1'b0, 0, 16'h0, 1'b1, 1'b1, c);
        scan_range(6, 15);
        scan_range(0, 15);
    endtask

    task automatic test_enable_pause();
        bit c;
        period_chk = 1'b0;
        scan_range(0, 6);
        scan_column(7, 1'b0, 0, 16'h0, 1'b0, 1'b0, c);
        check_idle(40);
        in_enable = 1'b1;
        @(negedge clk);
        scan_range(8, 15);
    endtask

    task automatic test_random_frames();
        bit c;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 16; k++) begin
                scan_column(k, 1'b1, int'($urandom_range(0, 15)), 16'($urandom),
                            (f == 0) && (k == 15), 1'b1, c);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        bit c;
        repeat (20) @(negedge clk);
        in_reset  = 1'b1;
        in_enable = 1'b0;
        @(negedge clk);
        n_total++;
        if ({out_row_clk, out_row_data, out_column, out_frame, out_swap_done, out_button, out_button_event} !==
            {1'b0, INV, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0})
            $display("FAIL reset_mid_shift got rc=%b rd=%b col=%0d frm=%b swp=%b btn=%0d ev=%b",
                     out_row_clk, out_row_data, out_column, out_frame, out_swap_done, out_button, out_button_event);
        else
            n_pass++;
        in_reset = 1'b0;
        model_clear();
        @(negedge clk);
        check_idle(5);
        in_enable = 1'b1;
        @(negedge clk);
        scan_column(0, 1'b0, 0, 16'h0, 1'b1, 1'b1, c);
        scan_range(1, 15);
        scan_range(0, 14);
        scan_column(15, 1'b0, 0, 16'h0, 1'b0, 1'b0, c);
        check_idle(5);
    endtask

    // Debounce model: the accepted code follows any code that stayed constant
    // for DEB cycles at the input, seen through a two-cycle synchroniser.
    task automatic test_buttons();
        int          hv[$];
        int          hr[$];
        int          seg_code[$];
        int          seg_len[$];
        int          cur, run, idx;
        logic [2:0]  mb, eb;
        logic        ee;
        bit          upd;
        for (int i = 0; i < 3; i++) begin
            hv.push_back(0);
            hr.push_back(100000);
        end
        cur = 0;
        run = 100000;
        mb  = 3'd0;
        for (int i = 0; i < 6; i++) begin
            seg_code.push_back((i % 2 == 0) ? 3 : 0);
            seg_len.push_back(100);
        end
        seg_code.push_back(3); seg_len.push_back(DEB + 60);
        seg_code.push_back(0); seg_len.push_back(DEB + 60);
        for (int i = 0; i < 3; i++) begin
            seg_code.push_back(int'($urandom_range(1, 7)));
            seg_len.push_back(int'($urandom_range(DEB - 150, DEB + 250)));
        end
        seg_code.push_back(0); seg_len.push_back(DEB + 60);
        for (int s = 0; s < seg_code.size(); s++) begin
            for (int k = 0; k < seg_len[s]; k++) begin
                idx = hv.size() - 3;
                upd = (hr[idx] >= DEB) && (3'(hv[idx]) != mb);
                eb  = upd ? 3'(hv[idx]) : mb;
                ee  = upd && (hv[idx] != 0);
                n_total++;
                if (out_button !== eb || out_button_event !== ee)
                    $display("FAIL button seg=%0d k=%0d got btn=%0d ev=%b want btn=%0d ev=%b",
                             s, k, out_button, out_button_event, eb, ee);
                else
                    n_pass++;
                mb = eb;
                in_button_code = 3'(seg_code[s]);
                run = (seg_code[s] == cur) ? run + 1 : 1;
                cur = seg_code[s];
                hv.push_back(cur);
                hr.push_back(run);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        period_chk = 1'b0;
        last_frame = -1;
        model_clear();
        test_reset();
        test_first_column();
        test_free_run();
        test_swap_midframe();
        test_enable_pause();
        test_random_frames();
        test_reset_mid_shift();
        test_buttons();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
